sseg_scan_ctrl: RTL
===================

# sseg_scan_ctrl

Parametrised, time-multiplexed seven-segment display controller for the Nios I/O subsystem. It replaces the static packed-segment output-port scheme with a register-mapped bank of N digit patterns. The digits are scanned onto one shared segment bus and per-digit anode enables. It adds brightness PWM, anti-ghosting blanking and a per-digit blink mask, and is written from the CPU through a simple synchronous register port.

## Interface
- `N_DIGITS`, default 4: number of digits (1..8).
- `SCAN_DIV`, default 16: digit slot length = 2**SCAN_DIV clocks; must be >= 4.
- `BLINK_DIV`, default 6: the blink phase toggles every 2**BLINK_DIV complete frames.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr` in 1: write strobe, single cycle.
- `rd` in 1: read strobe, single cycle.
- `addr` in AW: register address, AW = $clog2(N_DIGITS+2).
- `wdata` in 8: write data.
- `rdata` out 8: read data, registered.
- `an_n` out N_DIGITS: active-low digit enables.
- `sseg_n` out 8: active-low segments; bit7 = dp, bits 6:0 = g..a.

## Operation
- Register map:
  - addr 0..N_DIGITS-1: digit pattern, active-low, reset 8'hFF.
  - addr N_DIGITS: control. bit0 `en` (reset 0), bit1 `blink_en` (reset 0), bits7:4 `bright` (reset 4'hF). Bits 3:2 read 0.
  - addr N_DIGITS+1: blink mask, bits N_DIGITS-1:0, reset 0.
- Writes take effect on the clock edge where `wr`=1. Writes to unmapped addresses are ignored.
- Reads: `rdata` is valid one cycle after `rd`. Unmapped addresses return 8'h00. `rdata` holds its value when `rd`=0.
- Simultaneous `wr` and `rd` to the same address: `rdata` returns the old value.
- Scan:
  - The prescaler counts 0..2**SCAN_DIV-1.
  - At wrap, the digit index advances 0→1→…→N_DIGITS-1→0. A wrap from the last digit is a frame end.
  - Sub-phase `sp` = prescaler[SCAN_DIV-1:SCAN_DIV-4], range 0..15.
- Slot latch: at the first cycle of each slot, the pattern of the current digit is copied into an internal shadow. CPU writes during a slot never change the segments mid-slot.
- Digit on-condition, all required: `en`=1; `sp`≠0 (ghost guard); `sp` <= `bright`; and NOT(`blink_en` & mask[idx] & blink_off).
- Brightness:
  - `bright`=0 gives a fully dark display.
  - `bright`=15 gives 15/16 duty.
- Outputs:
  - Digit on: `an_n` = ~(1<<idx) and `sseg_n` = shadow.
  - Digit off: `an_n` = all ones and `sseg_n` = 8'hFF.
- Blink: a frame counter of BLINK_DIV bits toggles `blink_off` on wrap. The frame counter and `blink_off` are reset whenever `blink_en` goes 0→1.
- Clearing `en`:
  - Blanks the outputs on the next cycle.
  - The scan counters keep running.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). After deassertion, scanning restarts at digit 0, prescaler 0.

## Timing
- Reset values:
  - `an_n` = all ones.
  - `sseg_n` = 8'hFF.
  - `rdata` = 8'h00.
  - prescaler, digit index and frame counter = 0.
  - `blink_off` = 0.
- `an_n` and `sseg_n` are registered: they reflect the counter state of the previous cycle, which is one cycle of latency.
- A register write lands in the register at cycle T. It is visible on the outputs no earlier than the next slot start plus 1 cycle.
- Frame period = N_DIGITS × 2**SCAN_DIV clocks.
- Blink half-period = 2**BLINK_DIV frames.

## Structure
- Package `sseg_pkg` holds:
  - control bit positions (`EN_BIT`, `BLINK_BIT`, `BRIGHT_LSB`);
  - reset constants (`SEG_BLANK` = 8'hFF, `BRIGHT_RST` = 4'hF);
  - a register-offset function of N_DIGITS.
- Sub-module `sseg_scan_timer` owns the prescaler, digit index, sub-phase, frame-end pulse and blink phase. Its outputs are `idx`, `sp`, `slot_start` and `blink_off`.
- The top level owns the register file, the read mux, the shadow latch and the output drive.

## Test plan
All scenarios use N_DIGITS=4, SCAN_DIV=4 (16-clock slots, 1 clock per sub-phase), BLINK_DIV=1.
- Reset, no writes → `an_n`=4'hF and `sseg_n`=8'hFF for 200 cycles; a read of addr 4 returns 8'hF0.
- Write digits 0..3 = 8'hC0, F9, A4, B0, then control = 8'hF1 → the digits light in order 0,1,2,3. In each slot `an_n` is low for 15 of 16 cycles, is high at `sp`=0, and `sseg_n` matches that slot's digit pattern.
- Control = 8'h31 (`bright`=3) → each digit is lit only for `sp` 1..3, i.e. 3 cycles per slot. Control = 8'h01 → `an_n` is all ones for the whole slot.
- Blink mask = 8'h02, control = 8'hF3 → digit 1 is lit for 2 frames, then dark for 2 frames, repeating. Digits 0, 2 and 3 are unaffected.
- Write digit 2 = 8'h80 at mid-slot of digit 2 → the current slot still shows the old value; the next digit-2 slot shows 8'h80. A read of addr 7 returns 8'h00.
- Assert `reset` mid-slot of digit 3 → within the same cycle, `an_n`=4'hF and `sseg_n`=8'hFF. After deassertion, a read of addr 0 returns 8'hFF and scanning resumes at digit 0.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared constants and register-map helpers for the seven-segment scan controller.
package sseg_pkg;

    localparam int EN_BIT     = 0;
    localparam int BLINK_BIT  = 1;
    localparam int BRIGHT_LSB = 4;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [3:0] BRIGHT_RST = 4'hF;

    typedef enum logic [1:0] {
        REG_DIGIT,
        REG_CTRL,
        REG_MASK
    } reg_sel_e;

    // Digit patterns sit at 0..n_digits-1, followed by control and blink mask.
    function automatic int reg_offset(input int n_digits, input reg_sel_e sel);
        case (sel)
            REG_CTRL: return n_digits;
            REG_MASK: return n_digits + 1;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/sseg_scan_timer.sv
// Scan timebase: prescaler, digit index, sub-phase, slot start and blink phase.
module sseg_scan_timer #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 6,
    parameter int IW        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          blink_restart,
    output logic [IW-1:0] idx,
    output logic [3:0]    sp,
    output logic          slot_start,
    output logic          blink_off
);

    logic [SCAN_DIV-1:0]  prescaler;
    logic [BLINK_DIV-1:0] frame_cnt;
    logic                 slot_wrap;
    logic                 frame_end;

    assign slot_wrap  = &prescaler;
    assign frame_end  = slot_wrap && (idx == IW'(N_DIGITS - 1));
    assign slot_start = (prescaler == '0);
    assign sp         = prescaler[SCAN_DIV-1 -: 4];

    // Free-running prescaler; the digit index steps once per completed slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler + SCAN_DIV'(1);
            if (slot_wrap) begin
                if (idx == IW'(N_DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + IW'(1);
            end
        end
    end

    // Frame counter flips the blink phase on wrap; restarted when blinking is enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_restart) begin
            frame_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + BLINK_DIV'(1);
            if (&frame_cnt)
                blink_off <= ~blink_off;
        end
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Register-mapped, time-multiplexed seven-segment controller with PWM and blink.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic                          rd,
    input  logic [$clog2(N_DIGITS+2)-1:0] addr,
    input  logic [7:0]                    wdata,
    output logic [7:0]                    rdata,
    output logic [N_DIGITS-1:0]           an_n,
    output logic [7:0]                    sseg_n
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int AW = $clog2(N_DIGITS + 2);
    localparam logic [AW-1:0] CTRL_ADDR = AW'(reg_offset(N_DIGITS, REG_CTRL));
    localparam logic [AW-1:0] MASK_ADDR = AW'(reg_offset(N_DIGITS, REG_MASK));

    logic [7:0]          digit [N_DIGITS];
    logic                en;
    logic                blink_en;
    logic [3:0]          bright;
    logic [N_DIGITS-1:0] mask;
    logic [7:0]          shadow;
    logic [7:0]          rd_mux;
    logic [7:0]          cur_pat;
    logic [N_DIGITS-1:0] mask_sh;
    logic                blink_hide;
    logic                digit_on;
    logic                blink_restart;
    logic [IW-1:0]       idx;
    logic [3:0]          sp;
    logic                slot_start;
    logic                blink_off;

    // Blink phase restarts on the write that turns blinking on.
    assign blink_restart = wr && (addr == CTRL_ADDR) && wdata[BLINK_BIT] && !blink_en;

    sseg_scan_timer #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .IW        (IW)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .blink_restart (blink_restart),
        .idx           (idx),
        .sp            (sp),
        .slot_start    (slot_start),
        .blink_off     (blink_off)
    );

    // CPU register file; unmapped addresses are silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++)
                digit[i] <= SEG_BLANK;
            en       <= 1'b0;
            blink_en <= 1'b0;
            bright   <= BRIGHT_RST;
            mask     <= '0;
        end else if (wr) begin
            for (int i = 0; i < N_DIGITS; i++)
                if (addr == AW'(i))
                    digit[i] <= wdata;
            if (addr == CTRL_ADDR) begin
                en       <= wdata[EN_BIT];
                blink_en <= wdata[BLINK_BIT];
                bright   <= wdata[BRIGHT_LSB +: 4];
            end
            if (addr == MASK_ADDR)
                mask <= wdata[N_DIGITS-1:0];
        end
    end

    // Read mux; anything not decoded reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_DIGITS; i++)
            if (addr == AW'(i))
                rd_mux = digit[i];
        if (addr == CTRL_ADDR) begin
            rd_mux[EN_BIT]            = en;
            rd_mux[BLINK_BIT]         = blink_en;
            rd_mux[BRIGHT_LSB +: 4]   = bright;
        end
        if (addr == MASK_ADDR)
            rd_mux = 8'(mask);
    end

    // Registered read data, held between read strobes; same-cycle writes return old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata <= '0;
        else if (rd)
            rdata <= rd_mux;
    end

    // Pattern of the digit currently being scanned.
    always_comb begin
        cur_pat = SEG_BLANK;
        for (int i = 0; i < N_DIGITS; i++)
            if (idx == IW'(i))
                cur_pat = digit[i];
    end

    assign mask_sh    = mask >> idx;
    assign blink_hide = blink_en && mask_sh[0] && blink_off;
    assign digit_on   = en && (sp != 4'd0) && (sp <= bright) && !blink_hide;

    // Freeze the pattern at slot start so CPU writes never tear a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shadow <= SEG_BLANK;
        else if (slot_start)
            shadow <= cur_pat;
    end

    // Registered anode/segment drive; dark whenever the digit is gated off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_n   <= '1;
            sseg_n <= SEG_BLANK;
        end else if (digit_on) begin
            an_n   <= ~(N_DIGITS'(1) << idx);
            sseg_n <= shadow;
        end else begin
            an_n   <= '1;
            sseg_n <= SEG_BLANK;
        end
    end

endmodule
